// File: rtl/instr_pkg.sv
// rtl/instr_pkg.sv - shared loader/fetch types and word geometry constants
//
// Purpose: state encoding for the instruction loader plus the byte/word
//          geometry shared with the instruction memory and fetch path.
// Ports:   none (package).
package instr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int INSTR_DATA_WIDTH = 32;
    localparam int BYTES_PER_WORD   = INSTR_DATA_WIDTH / 8;
    localparam int WORD_SHIFT       = $clog2(BYTES_PER_WORD);

    // Byte-offset shift for an arbitrary word width (0 for byte-wide words).
    function automatic int word_shift(input int data_width);
        return (data_width / 8 > 1) ? $clog2(data_width / 8) : 0;
    endfunction

endpackage

// File: rtl/byte_word_packer.sv
// rtl/byte_word_packer.sv - little-endian byte-to-word assembly buffer
//
// Purpose: collects accepted stream bytes into a word, lowest byte first.
// Ports:
//   clk, rst        clock and asynchronous active-high reset
//   clear_i         restart at byte 0 (start of a new load)
//   accept_i        a byte is consumed this cycle
//   byte_i          the byte being consumed
//   word_o          assembled word buffer
//   last_byte_o     the next accepted byte completes the word
module byte_word_packer #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear_i,
    input  logic                  accept_i,
    input  logic [7:0]            byte_i,
    output logic [DATA_WIDTH-1:0] word_o,
    output logic                  last_byte_o
);

    localparam int BPW   = DATA_WIDTH / 8;
    localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;

    logic [CNT_W-1:0]      byte_cnt_q;
    logic [DATA_WIDTH-1:0] buf_q;

    assign last_byte_o = (byte_cnt_q == CNT_W'(BPW - 1));
    assign word_o      = buf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt_q <= '0;
            buf_q      <= '0;
        end else if (clear_i) begin
            byte_cnt_q <= '0;
        end else if (accept_i) begin
            buf_q[8*byte_cnt_q +: 8] <= byte_i;
            // Wrap to 0 on the final byte so the next word starts aligned.
            byte_cnt_q <= last_byte_o ? '0 : byte_cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - boot-time byte-stream loader for instruction memory
//
// Purpose: packs a byte stream into words and writes them to instruction
//          memory at consecutive word addresses from 0, holding the core in
//          reset while the load runs.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   load_start, load_len          load request and length in words
//   byte_valid, byte_data         stream input
//   byte_ready                    stream byte accepted when valid
//   mem_we, mem_addr, mem_wdata   instruction memory write port
//   cpu_hold                      core reset hold during a load
//   load_done, load_err           completion / rejection pulses
module instr_loader
    import instr_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int MEM_SIZE      = 512
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load_start,
    input  logic [$clog2(MEM_SIZE):0]    load_len,
    input  logic                         byte_valid,
    input  logic [7:0]                   byte_data,
    output logic                         byte_ready,
    output logic                         mem_we,
    output logic [ADDRESS_WIDTH-1:0]     mem_addr,
    output logic [DATA_WIDTH-1:0]        mem_wdata,
    output logic                         cpu_hold,
    output logic                         load_done,
    output logic                         load_err
);

    localparam int LEN_W = $clog2(MEM_SIZE) + 1;
    localparam int SHIFT = word_shift(DATA_WIDTH);

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   word_cnt_q;
    logic               err_q;
    logic               len_ok;
    logic               start_ok;
    logic               accept;
    logic               last_byte;
    logic               last_word;
    logic [DATA_WIDTH-1:0]    word_buf;
    logic [ADDRESS_WIDTH-1:0] word_addr;

    assign len_ok    = (load_len != '0) && (load_len <= LEN_W'(MEM_SIZE));
    assign start_ok  = (state_q == ST_IDLE) && load_start && len_ok;
    assign accept    = byte_valid && byte_ready;
    assign last_word = (word_cnt_q == len_q - LEN_W'(1));

    byte_word_packer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_packer (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (start_ok),
        .accept_i    (accept),
        .byte_i      (byte_data),
        .word_o      (word_buf),
        .last_byte_o (last_byte)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_ok) state_d = ST_RECV;
            ST_RECV:  if (accept && last_byte) state_d = ST_WRITE;
            ST_WRITE: state_d = last_word ? ST_DONE : ST_RECV;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Length, word counter and the registered rejection pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q      <= '0;
            word_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            err_q <= (state_q == ST_IDLE) && load_start && !len_ok;
            if (start_ok) begin
                len_q      <= load_len;
                word_cnt_q <= '0;
            end else if (state_q == ST_WRITE && !last_word) begin
                word_cnt_q <= word_cnt_q + LEN_W'(1);
            end
        end
    end

    assign word_addr = ADDRESS_WIDTH'(word_cnt_q);

    // Output decode: everything comes from registered state/counters/buffer
    always_comb begin
        byte_ready = (state_q == ST_RECV);
        mem_we     = (state_q == ST_WRITE);
        cpu_hold   = (state_q != ST_IDLE);
        load_done  = (state_q == ST_DONE);
        load_err   = err_q;
        mem_addr   = word_addr << SHIFT;
        mem_wdata  = word_buf;
    end

endmodule

// File: tb/tb_instr_loader.sv
// tb/tb_instr_loader.sv - scoreboard bench for instr_loader
module tb_instr_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_start;
    logic [9:0]  load_len;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;

    instr_loader #(
        .ADDRESS_WIDTH (32),
        .DATA_WIDTH    (32),
        .MEM_SIZE      (512)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .load_len   (load_len),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int writes_seen = 0;
    int done_seen   = 0;
    logic prev_we = 1'b0;
    logic [63:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write is matched against the scoreboard queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_we) begin
                logic [63:0] e;
                writes_seen++;
                if (exp_q.size() == 0) begin
                    check("unexpected_write_addr", {32'd0, mem_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("write_addr", {32'd0, mem_addr}, {32'd0, e[63:32]});
                    check("write_data", {32'd0, mem_wdata}, {32'd0, e[31:0]});
                end
            end
            if (load_done) begin
                done_seen++;
                check("done_after_write", {63'd0, prev_we}, 64'd1);
            end
            prev_we = mem_we;
        end else begin
            prev_we = 1'b0;
        end
    end

    task automatic start_load(input logic [9:0] len);
        @(posedge clk); #1;
        load_start = 1'b1;
        load_len   = len;
        @(posedge clk); #1;
        load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        logic acc;
        int   k;
        if (gap > 0) begin
            byte_valid = 1'b0;
            repeat (gap) @(posedge clk);
            #1;
        end
        byte_valid = 1'b1;
        byte_data  = b;
        acc = 1'b0;
        k = 0;
        while (!acc && k < 50) begin
            @(negedge clk);
            acc = byte_ready;
            @(posedge clk); #1;
            k++;
        end
        if (!acc) check("byte_accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_word(input logic [31:0] w, input int max_gap);
        for (int j = 0; j < 4; j++) begin
            logic [31:0] t;
            t = w >> (8 * j);
            send_byte(t[7:0], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
        end
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        byte_valid = 1'b0;
        @(negedge clk);
        while (!load_done && k < 20) begin
            @(negedge clk);
            k++;
        end
        check({name, "_done_seen"}, {63'd0, load_done}, 64'd1);
        check({name, "_hold_in_done"}, {63'd0, cpu_hold}, 64'd1);
        @(negedge clk);
        check({name, "_hold_released"}, {63'd0, cpu_hold}, 64'd0);
        check({name, "_done_one_cycle"}, {63'd0, load_done}, 64'd0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_byte_ready"}, {63'd0, byte_ready}, 64'd0);
        check({name, "_mem_we"},     {63'd0, mem_we},     64'd0);
        check({name, "_mem_addr"},   {32'd0, mem_addr},   64'd0);
        check({name, "_mem_wdata"},  {32'd0, mem_wdata},  64'd0);
        check({name, "_cpu_hold"},   {63'd0, cpu_hold},   64'd0);
        check({name, "_load_done"},  {63'd0, load_done},  64'd0);
        check({name, "_load_err"},   {63'd0, load_err},   64'd0);
    endtask

    initial begin
        int w0, d0;
        logic [31:0] wd;

        rst = 1'b1; load_start = 1'b0; load_len = '0;
        byte_valid = 1'b0; byte_data = '0;
        #2;
        check_reset_outputs("reset");
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Two-word load at full rate
        exp_q.push_back({32'h0, 32'h0050_0513});
        exp_q.push_back({32'h4, 32'h0010_0593});
        d0 = done_seen;
        start_load(10'd2);
        check("recv_after_start_ready", {63'd0, byte_ready}, 64'd1);
        check("recv_after_start_hold",  {63'd0, cpu_hold},   64'd1);
        send_word(32'h0050_0513, 0);
        send_word(32'h0010_0593, 0);
        wait_done("full_rate");
        check("full_rate_drained", exp_q.size(), 64'd0);
        check("full_rate_done_cnt", done_seen - d0, 64'd1);

        // Same data with random gaps in byte_valid
        exp_q.push_back({32'h0, 32'h0050_0513});
        exp_q.push_back({32'h4, 32'h0010_0593});
        w0 = writes_seen;
        start_load(10'd2);
        send_word(32'h0050_0513, 3);
        send_word(32'h0010_0593, 3);
        wait_done("gaps");
        check("gaps_drained", exp_q.size(), 64'd0);
        check("gaps_write_cnt", writes_seen - w0, 64'd2);

        // Rejected lengths
        w0 = writes_seen;
        start_load(10'd0);
        @(negedge clk);
        check("len0_err",   {63'd0, load_err},   64'd1);
        check("len0_ready", {63'd0, byte_ready}, 64'd0);
        check("len0_hold",  {63'd0, cpu_hold},   64'd0);
        @(negedge clk);
        check("len0_err_pulse", {63'd0, load_err}, 64'd0);
        start_load(10'd513);
        @(negedge clk);
        check("len513_err",   {63'd0, load_err},   64'd1);
        check("len513_ready", {63'd0, byte_ready}, 64'd0);
        check("len513_hold",  {63'd0, cpu_hold},   64'd0);
        @(negedge clk);
        check("len513_err_pulse", {63'd0, load_err}, 64'd0);
        check("len_err_no_write", writes_seen - w0, 64'd0);

        // Full 512-word load with a stray load_start mid-load
        for (int i = 0; i < 512; i++) begin
            wd = 32'h1000_0000 + 32'(i) * 32'h0001_0003;
            exp_q.push_back({32'(i * 4), wd});
        end
        w0 = writes_seen;
        start_load(10'd512);
        for (int i = 0; i < 512; i++) begin
            wd = 32'h1000_0000 + 32'(i) * 32'h0001_0003;
            if (i == 100) begin
                load_start = 1'b1;
                load_len   = 10'd1;
            end
            send_word(wd, 0);
            load_start = 1'b0;
        end
        wait_done("full_mem");
        check("full_mem_drained", exp_q.size(), 64'd0);
        check("full_mem_write_cnt", writes_seen - w0, 64'd512);

        // Reset after 6 bytes of a 3-word load
        exp_q.push_back({32'h0, 32'h4433_2211});
        w0 = writes_seen;
        start_load(10'd3);
        send_word(32'h4433_2211, 0);
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        byte_valid = 1'b0;
        #3 rst = 1'b1;
        #1;
        check_reset_outputs("mid_reset");
        check("mid_reset_one_write", writes_seen - w0, 64'd1);
        check("mid_reset_drained", exp_q.size(), 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        exp_q.push_back({32'h0, 32'hDEAD_BEEF});
        start_load(10'd1);
        send_word(32'hDEAD_BEEF, 0);
        wait_done("restart");
        check("restart_drained", exp_q.size(), 64'd0);

        // byte_valid while IDLE
        w0 = writes_seen;
        byte_valid = 1'b1;
        byte_data  = 8'hAB;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_no_ready", {63'd0, byte_ready}, 64'd0);
        end
        byte_valid = 1'b0;
        check("idle_no_write", writes_seen - w0, 64'd0);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
